// File: rtl/tns_enc_24_seq.sv
// Serial greedy TNS encoder: one code bit per clock, bit 23 first.
// Define TNS_ENC_RANGE_CHECK_EN to clamp out-of-range words and raise err.
`ifndef BLEN08
`define BLEN08 18
`endif

`ifndef TNS08_A
`define TNS01_C 1
`define TNS01_B 2
`define TNS01_A 3
`define TNS02_C 5
`define TNS02_B 8
`define TNS02_A 13
`define TNS03_C 21
`define TNS03_B 34
`define TNS03_A 55
`define TNS04_C 89
`define TNS04_B 144
`define TNS04_A 233
`define TNS05_C 377
`define TNS05_B 610
`define TNS05_A 987
`define TNS06_C 1597
`define TNS06_B 2584
`define TNS06_A 4181
`define TNS07_C 6765
`define TNS07_B 10946
`define TNS07_A 17711
`define TNS08_C 28657
`define TNS08_B 46368
`define TNS08_A 75025
`endif

module tns_enc_24_seq (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [`BLEN08-1:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [23:0]        codeout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        DONE
    } state_t;

    state_t             state;
    logic [`BLEN08-1:0] r;
    logic [`BLEN08-1:0] w;
    logic [`BLEN08-1:0] r_ld;
    logic [4:0]         idx;
    logic [23:0]        code;
    logic [23:0]        code_nxt;
    logic               accept;
    logic               take;

    assign din_ready = (state == IDLE);
    assign accept    = din_valid & din_ready;
    assign take      = (r >= w);

    always_comb begin
        w = '0;
        case (idx)
            5'd23:   w = `BLEN08'(`TNS08_A);
            5'd22:   w = `BLEN08'(`TNS08_B);
            5'd21:   w = `BLEN08'(`TNS08_C);
            5'd20:   w = `BLEN08'(`TNS07_A);
            5'd19:   w = `BLEN08'(`TNS07_B);
            5'd18:   w = `BLEN08'(`TNS07_C);
            5'd17:   w = `BLEN08'(`TNS06_A);
            5'd16:   w = `BLEN08'(`TNS06_B);
            5'd15:   w = `BLEN08'(`TNS06_C);
            5'd14:   w = `BLEN08'(`TNS05_A);
            5'd13:   w = `BLEN08'(`TNS05_B);
            5'd12:   w = `BLEN08'(`TNS05_C);
            5'd11:   w = `BLEN08'(`TNS04_A);
            5'd10:   w = `BLEN08'(`TNS04_B);
            5'd9:    w = `BLEN08'(`TNS04_C);
            5'd8:    w = `BLEN08'(`TNS03_A);
            5'd7:    w = `BLEN08'(`TNS03_B);
            5'd6:    w = `BLEN08'(`TNS03_C);
            5'd5:    w = `BLEN08'(`TNS02_A);
            5'd4:    w = `BLEN08'(`TNS02_B);
            5'd3:    w = `BLEN08'(`TNS02_C);
            5'd2:    w = `BLEN08'(`TNS01_A);
            5'd1:    w = `BLEN08'(`TNS01_B);
            5'd0:    w = `BLEN08'(`TNS01_C);
            default: w = '0;
        endcase
    end

    always_comb begin
        code_nxt      = code;
        code_nxt[idx] = take;
    end

`ifdef TNS_ENC_RANGE_CHECK_EN
    localparam logic [`BLEN08-1:0] TNS_MAX = `BLEN08'(
        `TNS08_A + `TNS08_B + `TNS08_C + `TNS07_A + `TNS07_B + `TNS07_C +
        `TNS06_A + `TNS06_B + `TNS06_C + `TNS05_A + `TNS05_B + `TNS05_C +
        `TNS04_A + `TNS04_B + `TNS04_C + `TNS03_A + `TNS03_B + `TNS03_C +
        `TNS02_A + `TNS02_B + `TNS02_C + `TNS01_A + `TNS01_B + `TNS01_C);

    logic over;
    logic err_q;

    // Clamping to the full weight sum makes greedy emit all ones.
    assign over = (din > TNS_MAX);
    assign r_ld = over ? TNS_MAX : din;
    assign err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= over;
        end
    end
`else
    assign r_ld = din;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r          <= '0;
            idx        <= '0;
            code       <= '0;
            codeout    <= '0;
            dout_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        r     <= r_ld;
                        code  <= '0;
                        idx   <= 5'd23;
                        state <= ENC;
                    end
                end
                ENC: begin
                    code <= code_nxt;
                    if (take) begin
                        r <= r - w;
                    end
                    // Output only ever shows a finished codeword.
                    if (idx == 5'd0) begin
                        codeout    <= code_nxt;
                        dout_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx - 5'd1;
                    end
                end
                DONE: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tns_enc_24_seq.md
# tns_enc_24_seq

Sequential TNS encoder for the 24-bit crosstalk-avoidance link. It is the transmit-side counterpart of `TNS_dec_24`. It converts one `BLEN08`-bit binary word into a 24-bit TNS codeword (8 groups of 3 bits). It uses greedy weight subtraction, resolving one code bit per clock from MSB to LSB. Round trip through `TNS_dec_24` is exact for every in-range input.

## Interface
Parameters:
- none. Data width is fixed at `` `BLEN08 `` and codeword width at 24. Weights are the `TNS.vh` macros.

Ports (clk/rst_n: one clock; reset is asynchronous and active-low):
- `clk` — input, 1 — single clock, rising edge.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `din` — input, `` `BLEN08 `` — binary word to encode.
- `din_valid` — input, 1 — `din` is valid.
- `din_ready` — output, 1 — encoder can accept a word.
- `codeout` — output, 24 — TNS codeword.
- `dout_valid` — output, 1 — `codeout` is valid.
- `dout_ready` — input, 1 — downstream accepts `codeout`.
- `err` — output, 1 — the input was out of range. Tied to 0 unless the macro in Configuration is defined.

## Operation
- Weight map, bit i ↔ weight W[i]:
  - bits 23..21 = `TNS08_A/B/C`
  - bits 20..18 = `TNS07_A/B/C`
  - … down to bits 2..0 = `TNS01_A/B/C`
  - This is the same map `TNS_dec_24` sums.
- Weights are constants selected by a 5-bit bit-index mux. No RAM.
- FSM states:
  - IDLE:
    - `din_ready` = 1.
    - On `din_valid & din_ready`: load residual R ← `din`, clear the code register, set idx ← 23, go to ENC.
  - ENC, one bit per cycle:
    - If R ≥ W[idx]: code[idx] ← 1 and R ← R − W[idx]. Otherwise code[idx] ← 0.
    - If idx == 0, go to DONE. Otherwise idx ← idx − 1.
  - DONE:
    - `dout_valid` = 1. `codeout` and `err` are held stable.
    - On `dout_ready`, go to IDLE.
- Arithmetic rules:
  - R is a `` `BLEN08 `` unsigned value.
  - The comparison is an unsigned magnitude compare.
  - The subtraction never underflows, because it is guarded by the compare.
- Only one word is in flight. `din_ready` is 0 in ENC and DONE.
- `din` is sampled only on the accept edge. Later changes to `din` are ignored.
- `dout_ready` is ignored outside DONE.
- Reset mid-operation clears all state immediately. The in-flight word is discarded and no partial codeword is ever presented.

## Timing
- Reset values:
  - state = IDLE
  - `din_ready` = 1 (combinational from state)
  - `dout_valid` = 0
  - `codeout` = 24'h000000
  - `err` = 0
  - R = 0, idx = 0
- Accept at edge T0. ENC occupies edges T1..T24, and DONE is entered at T24.
- `dout_valid` rises in the cycle after edge T24. Latency from accept to valid is 24 cycles.
- If `dout_ready` is already high, the handshake completes at the next edge (T25). `din_ready` is high after T25, and the next accept can occur at T26.
- Maximum throughput is 1 word per 26 cycles.
- Back-pressure: DONE is held indefinitely while `dout_ready` = 0. `codeout` must not change while `dout_valid` = 1.
- `dout_valid` and `din_ready` are never high in the same cycle.

## Configuration
- Macro: `TNS_ENC_RANGE_CHECK_EN`.
- When defined:
  - On accept, compare `din` against `TNS_MAX`, the sum of all 24 weights computed as a constant.
  - If `din` > `TNS_MAX`: `err` is registered to 1, R is forced to `TNS_MAX`, and the result is `codeout` = 24'hFFFFFF.
  - Latency is unchanged.
  - `err` clears when the next word is accepted.
- When undefined:
  - `err` is tied to 0 and no compare logic exists.
  - An out-of-range input leaves a nonzero R after bit 0. That remainder is silently dropped, so the decode does not equal `din`.

## Test plan
- Reset release, then `din`=0 with `din_valid`=1 → accepted on the first edge; `codeout`=24'h000000 and `dout_valid`=1 exactly 24 cycles later; `err`=0.
- `din` = `TNS01_C` → `codeout`=24'h000001. `din` = `TNS08_A` → `codeout` bit 23 set, and `TNS_dec_24` of the result equals `din`.
- 1000 random in-range words, with `dout_ready` randomly toggled → `TNS_dec_24(codeout)` == `din` for every word; `codeout` stable throughout every stall; no new accept occurs before each output handshake.
- `rst_n` pulsed low at ENC cycle 10 → `dout_valid` is never asserted for that word; the outputs return to their reset values asynchronously; the next word encodes correctly.
- With `TNS_ENC_RANGE_CHECK_EN`: `din` = `TNS_MAX` → `codeout`=24'hFFFFFF, `err`=0. `din` = `TNS_MAX`+1 → `codeout`=24'hFFFFFF, `err`=1. A following `din`=0 → `err`=0.
